// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 receive path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  localparam int   DATA_BITS  = 8;
  localparam int   FRAME_BITS = 11;
  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;

  // PS/2 uses odd parity: data bits plus the parity bit hold an odd number of ones.
  function automatic logic odd_parity_ok(input logic [DATA_BITS-1:0] d, input logic p);
    return ^{d, p};
  endfunction

endpackage

// File: rtl/ps2_fall_det.sv
// Registers the filtered PS/2 clock and data once and flags PS/2 clock falling edges.
// Latency: fall is high the cycle after ps2_clk_f is first sampled low; dat_s is one cycle behind ps2_dat.
// Backpressure: none; free-running capture.
module ps2_fall_det (
  input  logic clk,
  input  logic rst,
  input  logic ps2_clk_f,
  input  logic ps2_dat,
  output logic fall,
  output logic dat_s
);

  logic clk_s;
  logic clk_d;

  // Reset to the idle-high line level so leaving reset never looks like an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_s <= 1'b1;
      clk_d <= 1'b1;
      dat_s <= 1'b1;
    end else begin
      clk_s <= ps2_clk_f;
      clk_d <= clk_s;
      dat_s <= ps2_dat;
    end
  end

  assign fall = clk_d & ~clk_s;

endmodule

// File: rtl/ps2_rx_ctrl.sv
// PS/2 frame receiver: start, 8 data bits LSB-first, odd parity, stop; emits good bytes and error strobes.
// Latency: rx_valid/rx_err rise on the edge that consumes the stop-bit fall (2 clk after the PS/2 clock drops).
// Backpressure: none; strobes last one cycle and must be taken by the consumer when presented.
module ps2_rx_ctrl
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 5000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       ps2_clk_f,
  input  logic       ps2_dat,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_err,
  output logic       busy
);

  localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int BCW = $clog2(DATA_BITS);
  // Abort fires on the edge where the counter would step to TIMEOUT_CYCLES-1.
  localparam logic [TW-1:0]  TO_HIT   = TW'(TIMEOUT_CYCLES - 2);
  localparam logic [BCW-1:0] BIT_LAST = BCW'(DATA_BITS - 1);

  logic fall;
  logic dat_s;

  state_t               state, state_nxt;
  logic [BCW-1:0]       bit_cnt, bit_cnt_nxt;
  logic [DATA_BITS-1:0] shreg, shreg_nxt;
  logic                 par, par_nxt;
  logic [TW-1:0]        to_cnt, to_cnt_nxt;
  logic [7:0]           rx_data_nxt;
  logic                 rx_valid_nxt;
  logic                 rx_err_nxt;
  logic                 timeout;

  ps2_fall_det u_fall_det (
    .clk       (clk),
    .rst       (rst),
    .ps2_clk_f (ps2_clk_f),
    .ps2_dat   (ps2_dat),
    .fall      (fall),
    .dat_s     (dat_s)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      shreg    <= '0;
      par      <= 1'b0;
      to_cnt   <= '0;
      rx_data  <= 8'h00;
      rx_valid <= 1'b0;
      rx_err   <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_nxt;
      bit_cnt  <= bit_cnt_nxt;
      shreg    <= shreg_nxt;
      par      <= par_nxt;
      to_cnt   <= to_cnt_nxt;
      rx_data  <= rx_data_nxt;
      rx_valid <= rx_valid_nxt;
      rx_err   <= rx_err_nxt;
      busy     <= (state_nxt != IDLE);
    end
  end

  always_comb begin
    state_nxt    = state;
    bit_cnt_nxt  = bit_cnt;
    shreg_nxt    = shreg;
    par_nxt      = par;
    to_cnt_nxt   = '0;
    rx_data_nxt  = rx_data;
    rx_valid_nxt = 1'b0;
    rx_err_nxt   = 1'b0;

    // A fall arriving on the timeout cycle wins: it clears the counter instead.
    timeout = (state != IDLE) && !fall && (to_cnt == TO_HIT);
    if (state != IDLE && !fall) begin
      to_cnt_nxt = to_cnt + 1'b1;
    end

    case (state)
      IDLE: begin
        if (fall && dat_s == START_BIT) begin
          state_nxt   = DATA;
          bit_cnt_nxt = '0;
        end
      end
      DATA: begin
        if (fall) begin
          shreg_nxt[bit_cnt] = dat_s;
          if (bit_cnt == BIT_LAST) begin
            state_nxt = PARITY;
          end else begin
            bit_cnt_nxt = bit_cnt + 1'b1;
          end
        end
      end
      PARITY: begin
        if (fall) begin
          par_nxt   = dat_s;
          state_nxt = STOP;
        end
      end
      STOP: begin
        if (fall) begin
          state_nxt = IDLE;
          if (dat_s == STOP_BIT && odd_parity_ok(shreg, par)) begin
            rx_data_nxt  = shreg;
            rx_valid_nxt = 1'b1;
          end else begin
            rx_err_nxt = 1'b1;
          end
        end
      end
    endcase

    if (timeout) begin
      state_nxt  = IDLE;
      rx_err_nxt = 1'b1;
      to_cnt_nxt = '0;
    end

    // Disable aborts silently; capture flops keep tracking the line.
    if (!en) begin
      state_nxt    = IDLE;
      bit_cnt_nxt  = '0;
      to_cnt_nxt   = '0;
      rx_data_nxt  = rx_data;
      rx_valid_nxt = 1'b0;
      rx_err_nxt   = 1'b0;
    end
  end

endmodule
